unsigned_i2s_tx: RTL and testbench
==================================

UNSIGNED_I2S_TX -- requirements
Module: unsigned_i2s_tx

Interface
REQ-001 SHALL have parameter W, default 16: width of unsigned input samples, legal range 1..16.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO depth in stereo pairs, a power of two, at least 2.
REQ-003 SHALL have parameter BCLK_DIV, default 4: clk cycles per BCLK half-period, at least 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port cen, input, 1 bit: sample strobe; left/right are valid in any clk cycle where cen=1.
REQ-007 SHALL have ports left and right, input, W bits each: unsigned (offset-binary) samples from the mixer.
REQ-008 SHALL have port bclk, output, 1 bit: I2S bit clock.
REQ-009 SHALL have port lrck, output, 1 bit: I2S word select; 0 = left, 1 = right.
REQ-010 SHALL have port sdata, output, 1 bit: I2S serial data, MSB first.
REQ-011 SHALL have port level, output, $clog2(DEPTH)+1 bits: number of pairs held in the FIFO.
REQ-012 SHALL have port overrun, output, 1 bit: one-clk pulse when a sample is dropped.
REQ-013 SHALL have port underrun, output, 1 bit: one-clk pulse when a frame starts with the FIFO empty.

Function
REQ-014 SHALL convert each input to signed by inverting its MSB, then left-justify it to 16 bits with zero LSB padding.
REQ-015 SHALL push the converted pair on cen=1 when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-016 SHALL drop the pair on cen=1 with a full FIFO and no same-cycle pop, leave the FIFO contents unchanged, and pulse overrun for one cycle.
REQ-017 SHALL generate bclk from a divider that toggles bclk every BCLK_DIV clk cycles, giving a BCLK period of 2*BCLK_DIV clk cycles.
REQ-018 SHALL run a 5-bit slot counter that advances modulo 32 on each BCLK falling edge (the clk cycle in which bclk goes 1->0).
REQ-019 SHALL update sdata and lrck only on BCLK falling edges.
REQ-020 SHALL transmit left bits 15..0 in slots 0..15 and right bits 15..0 in slots 16..31.
REQ-021 SHALL drive lrck=1 during slots 15..30 and lrck=0 during slots 31 and 0..14, so that lrck leads each MSB by one BCLK.
REQ-022 SHALL, on the falling edge that enters slot 0, pop the FIFO head into a 32-bit shift register and also copy it into a last-pair register.
REQ-023 SHALL, on entering slot 0 with the FIFO empty, pulse underrun for one cycle and load the pair defined in Configuration.
REQ-024 SHALL NOT bypass the FIFO: a pair pushed in the same cycle as an empty-FIFO slot-0 load is transmitted in the following frame.
REQ-025 SHALL keep level equal to pushes minus pops; a simultaneous push and pop leaves level unchanged.
REQ-026 SHALL take 64*BCLK_DIV clk cycles per frame.
REQ-027 SHALL flag an error in simulation and stop if W>16, if DEPTH is not a power of two, or if BCLK_DIV<1.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force the following reset values:
- bclk=0, lrck=0, sdata=0
- slot counter=31, divider=0
- FIFO empty, level=0
- shift register and last-pair register all-zero
- overrun=0, underrun=0
REQ-029 SHALL enter slot 0 on the first BCLK falling edge after rst_n rises; if the FIFO is empty at that edge, this is an underrun.
REQ-030 SHALL, when reset is asserted mid-frame, abandon the frame at once and discard all FIFO contents.

Configuration
REQ-031 SHALL recognise the macro UNSIGNED_I2S_TX_MUTE_ON_UNDERRUN_EN.
REQ-032 SHALL, when the macro is defined, load a signed-zero (silent) pair (0x0000/0x0000) on underrun.
REQ-033 SHALL, when the macro is undefined, reload the last-pair register on underrun, repeating the previous frame.

Verification
REQ-034 W=16, BCLK_DIV=2: push left=0xFFFF, right=0x0000 -> next frame sdata slots 0..15 = 0x7FFF and slots 16..31 = 0x8000; lrck rises at slot 15 and falls at slot 31.
REQ-035 W=8: push left=0x80, right=0x7F -> left word 0x0000, right word 0xFF00.
REQ-036 DEPTH=4: five cen pulses with no frame boundary -> level=4, exactly one overrun pulse on the fifth push, FIFO holds the first four pairs.
REQ-037 Empty FIFO at slot 0 after a frame of 0x1234/0x5678 -> underrun pulses once; the frame carries 0x0000/0x0000 with the macro defined and 0x1234/0x5678 without it.
REQ-038 FIFO full, cen=1 in the same cycle as the slot-0 pop -> no overrun and level stays 4.
REQ-039 rst_n low at slot 20 -> all outputs take reset values immediately; after release the first slot-0 edge underruns with a zero pair.

Source files
------------

// File: rtl/unsigned_i2s_tx_if.sv
// Purpose : sample-side and I2S-side signal bundle for unsigned_i2s_tx.
// Latency : n/a (wiring only).
// Backpressure: none; the sample source offers a pair on cen and never stalls.
//
// Signals:
//   cen          - sample strobe, left/right valid in any cycle where cen=1
//   left, right  - unsigned (offset-binary) W-bit samples
//   bclk         - I2S bit clock
//   lrck         - I2S word select, 0 = left, 1 = right
//   sdata        - I2S serial data, MSB first
// Modports: master = sample source / I2S sink, slave = the transmitter.

interface unsigned_i2s_tx_if #(
  parameter int W = 16
) ();

  logic         cen;
  logic [W-1:0] left;
  logic [W-1:0] right;
  logic         bclk;
  logic         lrck;
  logic         sdata;

  modport master (
    output cen,
    output left,
    output right,
    input  bclk,
    input  lrck,
    input  sdata
  );

  modport slave (
    input  cen,
    input  left,
    input  right,
    output bclk,
    output lrck,
    output sdata
  );

endinterface

// File: rtl/unsigned_i2s_tx.sv
// Purpose : converts unsigned stereo samples to signed 16-bit and serialises
//           them as a standard I2S stream through a small pair FIFO.
// Latency : a pair pushed before a frame boundary goes out in the next frame
//           (64*BCLK_DIV clk per frame); never bypasses the FIFO.
// Backpressure: none upstream; a pair offered to a full FIFO (with no pop in
//           the same cycle) is dropped and flagged on overrun.
//
// Ports:
//   clk, rst_n     - single clock (rising edge), asynchronous active-low reset
//   bus (slave)    - cen/left/right sample input, bclk/lrck/sdata I2S output
//   level          - pairs currently held in the FIFO
//   overrun        - one-clk pulse when an offered pair is dropped
//   underrun       - one-clk pulse when a frame starts with the FIFO empty
//
// Option macro UNSIGNED_I2S_TX_MUTE_ON_UNDERRUN_EN: when defined an underrun
// frame carries silence (0x0000/0x0000); otherwise the last popped pair is
// repeated.

module unsigned_i2s_tx #(
  parameter int W        = 16,
  parameter int DEPTH    = 4,
  parameter int BCLK_DIV = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  unsigned_i2s_tx_if.slave       bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overrun,
  output logic                   underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(BCLK_DIV - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  // Elaboration-time parameter guards.
  if (W < 1 || W > 16) begin : g_bad_w
    $fatal(1, "unsigned_i2s_tx: W must be in 1..16");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "unsigned_i2s_tx: DEPTH must be a power of two >= 2");
  end
  if (BCLK_DIV < 1) begin : g_bad_div
    $fatal(1, "unsigned_i2s_tx: BCLK_DIV must be >= 1");
  end

  // Offset-binary to two's complement: flipping the MSB after left-justifying
  // is the same as flipping the input MSB, and keeps W=1 legal.
  function automatic logic [15:0] to_s16(input logic [W-1:0] x);
    logic [15:0] t;
    t     = 16'(x) << (16 - W);
    t[15] = ~t[15];
    return t;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [DW-1:0] div;
  logic          bclk_r;
  logic          lrck_r;
  logic          sdata_r;
  logic [4:0]    slot;
  logic [31:0]   shreg;
  logic [31:0]   last_pair;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // ---------------------------------------------------------------------
  // Frame timing
  // ---------------------------------------------------------------------
  logic       div_wrap;
  logic       fall;
  logic [4:0] slot_nxt;
  logic       frame_start;
  logic       lrck_nxt;

  assign div_wrap    = (div == DIV_LAST);
  // bclk is about to go 1->0: this is the only cycle that moves the slot.
  assign fall        = div_wrap & bclk_r;
  assign slot_nxt    = slot + 5'd1;
  assign frame_start = fall & (slot_nxt == 5'd0);
  // Word select switches one slot ahead of each MSB (slots 15 and 31).
  assign lrck_nxt    = (slot_nxt >= 5'd15) && (slot_nxt <= 5'd30);

  // ---------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------
  logic        empty;
  logic        full;
  logic        pop;
  logic        push;
  logic        drop;
  logic [31:0] in_pair;
  logic [31:0] head;
  logic [31:0] fill_pair;
  logic [31:0] load_dat;

  assign empty   = (level == '0);
  assign full    = (level == LEVEL_FULL);
  assign pop     = frame_start & ~empty;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push    = bus.cen & (~full | pop);
  assign drop    = bus.cen & full & ~pop;
  assign in_pair = {to_s16(bus.left), to_s16(bus.right)};
  assign head    = mem[rd_ptr];

`ifdef UNSIGNED_I2S_TX_MUTE_ON_UNDERRUN_EN
  assign fill_pair = 32'h0000_0000;
`else
  assign fill_pair = last_pair;
`endif

  // Empty at frame start: send the fill pair. A pair pushed this very cycle
  // is not visible here and waits for the next frame.
  assign load_dat = empty ? fill_pair : head;

  // Storage has no reset; validity is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_pair;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div       <= '0;
      bclk_r    <= 1'b0;
      lrck_r    <= 1'b0;
      sdata_r   <= 1'b0;
      slot      <= 5'd31;
      shreg     <= '0;
      last_pair <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      overrun  <= drop;
      underrun <= frame_start & empty;

      // Bit clock divider.
      if (div_wrap) begin
        div    <= '0;
        bclk_r <= ~bclk_r;
      end else begin
        div <= div + DW'(1);
      end

      // Serialiser: everything visible on the I2S pins changes on the
      // falling bclk edge so the receiver samples mid-bit on the rising edge.
      if (fall) begin
        slot   <= slot_nxt;
        lrck_r <= lrck_nxt;
        if (frame_start) begin
          sdata_r <= load_dat[31];
          shreg   <= {load_dat[30:0], 1'b0};
        end else begin
          sdata_r <= shreg[31];
          shreg   <= {shreg[30:0], 1'b0};
        end
      end

      if (pop) begin
        last_pair <= head;
        rd_ptr    <= rd_ptr + AW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end

      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign bus.bclk  = bclk_r;
  assign bus.lrck  = lrck_r;
  assign bus.sdata = sdata_r;

endmodule

// File: tb/tb_unsigned_i2s_tx.sv
// Purpose : directed bench for unsigned_i2s_tx (W=16 and W=8 instances run
//           in lockstep, DEPTH=4, BCLK_DIV=2).
// Latency : frames are read back serially from the I2S pins.
// Backpressure: n/a.

module tb_unsigned_i2s_tx;

  localparam int DIV   = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 64 * DIV;

`ifdef UNSIGNED_I2S_TX_MUTE_ON_UNDERRUN_EN
  localparam logic [31:0] REPB16 = 32'h0000_0000;
  localparam logic [31:0] REPB8  = 32'h0000_0000;
  localparam logic [31:0] REPD16 = 32'h0000_0000;
  localparam logic [31:0] REPD8  = 32'h0000_0000;
`else
  localparam logic [31:0] REPB16 = 32'h1234_5678;
  localparam logic [31:0] REPB8  = 32'h8000_7F00;
  localparam logic [31:0] REPD16 = 32'hC321_8F0F;
  localparam logic [31:0] REPD8  = 32'hC300_8F00;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  unsigned_i2s_tx_if #(.W(16)) bus16 ();
  unsigned_i2s_tx_if #(.W(8))  bus8 ();

  logic [2:0] level16, level8;
  logic       ov16, ud16, ov8, ud8;

  unsigned_i2s_tx #(.W(16), .DEPTH(DEPTH), .BCLK_DIV(DIV)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16),
    .level(level16), .overrun(ov16), .underrun(ud16)
  );

  unsigned_i2s_tx #(.W(8), .DEPTH(DEPTH), .BCLK_DIV(DIV)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8),
    .level(level8), .overrun(ov8), .underrun(ud8)
  );

  int errors = 0;
  int checks = 0;
  int ov_cnt = 0, ud_cnt = 0, ov8_cnt = 0, ud8_cnt = 0;

  always @(negedge clk) begin
    if (ov16) ov_cnt++;
    if (ud16) ud_cnt++;
    if (ov8)  ov8_cnt++;
    if (ud8)  ud8_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic cen, input logic [15:0] l16, input logic [15:0] r16,
                       input logic [7:0] l8, input logic [7:0] r8);
    bus16.cen = cen; bus16.left = l16; bus16.right = r16;
    bus8.cen  = cen; bus8.left  = l8;  bus8.right  = r8;
  endtask

  task automatic wait_bclk_rise(output bit ok);
    logic p;
    p  = bus16.bclk;
    ok = 1'b0;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      if (!p && bus16.bclk) begin ok = 1'b1; break; end
      p = bus16.bclk;
    end
  endtask

  task automatic wait_lrck_fall(output bit ok);
    logic p;
    p  = bus16.lrck;
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (p && !bus16.lrck) begin ok = 1'b1; break; end
      p = bus16.lrck;
    end
  endtask

  task automatic wait_underrun(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (ud16) begin ok = 1'b1; break; end
    end
  endtask

  // Position just after the slot-31 rising bclk, so the next rise is slot 0.
  task automatic sync_frame(input string tag);
    bit ok;
    wait_lrck_fall(ok);
    chk({tag, "/lrck_fall_seen"}, 32'(ok), 32'd1);
    wait_bclk_rise(ok);
    chk({tag, "/bclk_rise_seen"}, 32'(ok), 32'd1);
  endtask

  // Sample 32 slots on rising bclk, MSB first, and compare both streams and
  // the word-select pattern (high in slots 15..30).
  task automatic check_frame(input string tag, input logic [31:0] exp16, input logic [31:0] exp8);
    logic [31:0] d16, d8, lr;
    bit ok, all_ok;
    all_ok = 1'b1;
    d16 = '0; d8 = '0; lr = '0;
    for (int i = 0; i < 32; i++) begin
      wait_bclk_rise(ok);
      if (!ok) all_ok = 1'b0;
      d16[31-i] = bus16.sdata;
      d8[31-i]  = bus8.sdata;
      lr[31-i]  = bus16.lrck;
    end
    chk({tag, "/bclk_alive"}, 32'(all_ok), 32'd1);
    chk({tag, "/w16_pair"}, d16, exp16);
    chk({tag, "/w8_pair"}, d8, exp8);
    chk({tag, "/lrck_slots"}, lr, 32'h0001_FFFE);
  endtask

  // Back-to-back pairs for the overrun test; the fifth one must be dropped.
  logic [15:0] c_l16 [5] = '{16'h0001, 16'h8000, 16'hA5A5, 16'h1234, 16'hDEAD};
  logic [15:0] c_r16 [5] = '{16'hFFFE, 16'h7FFF, 16'h5A5A, 16'hFEDC, 16'hBEEF};
  logic [7:0]  c_l8  [5] = '{8'h01, 8'h81, 8'hA5, 8'h12, 8'hDE};
  logic [7:0]  c_r8  [5] = '{8'hFE, 8'h7E, 8'h5A, 8'hFE, 8'hBE};
  logic [31:0] c_e16 [4] = '{32'h8001_7FFE, 32'h0000_FFFF, 32'h25A5_DA5A, 32'h9234_7EDC};
  logic [31:0] c_e8  [4] = '{32'h8100_7E00, 32'h0100_FE00, 32'h2500_DA00, 32'h9200_7E00};

  initial begin
    bit ok;
    int base, n;
    logic p;

    drive(1'b0, 16'h0, 16'h0, 8'h0, 8'h0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst/bclk", 32'(bus16.bclk), 32'd0);
    chk("rst/lrck", 32'(bus16.lrck), 32'd0);
    chk("rst/sdata", 32'(bus16.sdata), 32'd0);
    chk("rst/level", 32'(level16), 32'd0);
    chk("rst/overrun", 32'(ov16), 32'd0);
    chk("rst/underrun", 32'(ud16), 32'd0);

    // First slot-0 edge after reset finds an empty FIFO.
    rst_n = 1'b1;
    wait_underrun(ok);
    chk("first_underrun_seen", 32'(ok), 32'd1);
    #1;
    chk("first_underrun_count", 32'(ud_cnt), 32'd1);

    // A: full-scale left / zero right. B: produces 0x1234/0x5678.
    drive(1'b1, 16'hFFFF, 16'h0000, 8'h80, 8'h7F);
    @(negedge clk);
    drive(1'b1, 16'h9234, 16'hD678, 8'h00, 8'hFF);
    @(negedge clk);
    drive(1'b0, 16'h0, 16'h0, 8'h0, 8'h0);
    chk("level_after_two", 32'(level16), 32'd2);

    sync_frame("sync1");
    check_frame("A", 32'h7FFF_8000, 32'h0000_FF00);
    chk("level_after_A", 32'(level16), 32'd1);
    check_frame("B", 32'h1234_5678, 32'h8000_7F00);
    check_frame("underrun_after_B", REPB16, REPB8);
    #1;
    chk("underrun_count_B", 32'(ud_cnt), 32'd2);
    chk("underrun_count_w8", 32'(ud8_cnt), 32'd2);

    // Five pushes inside one frame into a depth-4 FIFO.
    wait_underrun(ok);
    chk("underrun3_seen", 32'(ok), 32'd1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, c_l16[i], c_r16[i], c_l8[i], c_r8[i]);
      @(negedge clk);
    end
    drive(1'b0, 16'h0, 16'h0, 8'h0, 8'h0);
    @(negedge clk);
    #1;
    chk("overrun_once", 32'(ov_cnt), 32'd1);
    chk("overrun_once_w8", 32'(ov8_cnt), 32'd1);
    chk("level_full", 32'(level16), 32'd4);
    chk("level_full_w8", 32'(level8), 32'd4);

    // Push in exactly the cycle of the slot-0 pop with a full FIFO.
    wait_lrck_fall(ok);
    chk("lrck_fall_before_pop", 32'(ok), 32'd1);
    repeat (2 * DIV - 1) @(negedge clk);
    drive(1'b1, 16'h4321, 16'h0F0F, 8'h43, 8'h0F);
    @(negedge clk);
    drive(1'b0, 16'h0, 16'h0, 8'h0, 8'h0);
    chk("level_push_pop", 32'(level16), 32'd4);
    @(negedge clk);
    #1;
    chk("no_overrun_on_pop", 32'(ov_cnt), 32'd1);
    chk("no_underrun_when_full", 32'(ud_cnt), 32'd3);

    for (int i = 0; i < 4; i++) begin
      check_frame($sformatf("C%0d", i), c_e16[i], c_e8[i]);
    end
    check_frame("D", 32'hC321_8F0F, 32'hC300_8F00);
    #1;
    chk("underrun_count_D", 32'(ud_cnt), 32'd3);
    check_frame("underrun_after_D", REPD16, REPD8);

    // Reset mid-frame at slot 20 with one pair queued.
    for (int i = 0; i < 16; i++) begin
      wait_bclk_rise(ok);
    end
    drive(1'b1, 16'hCAFE, 16'hF00D, 8'hCA, 8'hF0);
    @(negedge clk);
    drive(1'b0, 16'h0, 16'h0, 8'h0, 8'h0);
    for (int i = 0; i < 5; i++) begin
      wait_bclk_rise(ok);
    end
    chk("pre_rst/lrck", 32'(bus16.lrck), 32'd1);
    chk("pre_rst/bclk", 32'(bus16.bclk), 32'd1);
    chk("pre_rst/level", 32'(level16), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst/bclk", 32'(bus16.bclk), 32'd0);
    chk("mid_rst/lrck", 32'(bus16.lrck), 32'd0);
    chk("mid_rst/sdata", 32'(bus16.sdata), 32'd0);
    chk("mid_rst/level", 32'(level16), 32'd0);
    chk("mid_rst/level_w8", 32'(level8), 32'd0);
    repeat (3) @(negedge clk);
    base = ud_cnt;
    rst_n = 1'b1;
    wait_underrun(ok);
    chk("post_rst_underrun_seen", 32'(ok), 32'd1);
    #1;
    chk("post_rst_underrun_once", 32'(ud_cnt), 32'(base + 1));
    check_frame("post_rst_zero", 32'h0000_0000, 32'h0000_0000);
    chk("post_rst_level", 32'(level16), 32'd0);

    // Frame length between successive word-select falls.
    wait_lrck_fall(ok);
    chk("len_sync", 32'(ok), 32'd1);
    n = 0;
    p = bus16.lrck;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      n++;
      if (p && !bus16.lrck) break;
      p = bus16.lrck;
    end
    chk("frame_len", 32'(n), 32'(FRAME));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
